stream_packet_arbiter: RTL and testbench
========================================

Name: stream_packet_arbiter

Overview:
- Packet-level round-robin arbiter: merges NUM_PORTS Avalon-ST style 32-bit packet streams onto one output stream.
- Sits in front of the ICMP echo responder and any other single-stream consumer, so several packet sources (e.g. tun/tap driver, test generators) share one datapath.
- A grant is held for a whole packet (SOP to EOP); packets are never interleaved.
- Stray beats arriving outside a packet on an idle port are discarded and counted.

Parameters:
- NUM_PORTS, 2, number of input streams (2..8).
- CH_W, 1, width of out_channel; must equal max(1, clog2(NUM_PORTS)).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- stream_in_data  in  NUM_PORTS*32  port p occupies bits [p*32+31:p*32].
- stream_in_empty  in  NUM_PORTS*2  port p occupies [p*2+1:p*2]; empty bytes on the EOP beat.
- stream_in_valid  in  NUM_PORTS  per-port valid.
- stream_in_startofpacket  in  NUM_PORTS  per-port SOP.
- stream_in_endofpacket  in  NUM_PORTS  per-port EOP.
- stream_in_ready  out  NUM_PORTS  per-port ready.
- stream_out_data  out  32  granted port's data.
- stream_out_empty  out  2  granted port's empty.
- stream_out_valid  out  1  output valid.
- stream_out_startofpacket  out  1  output SOP.
- stream_out_endofpacket  out  1  output EOP.
- stream_out_channel  out  CH_W  index of the granted port.
- stream_out_ready  in  1  downstream ready.
- drop_count  out  16  saturating count of discarded stray beats.

Behaviour:
- Reset (synchronous, reset=1 at a clk edge):
  - state=S_IDLE, grant=0, last_grant=NUM_PORTS-1 (port 0 wins first), drop_count=0.
  - During and after reset: all stream_in_ready=0, stream_out_valid=0.
  - Reset mid-packet abandons the packet. The downstream sees a truncated packet (no EOP); the upstream must also be reset.
- Accepted beat: valid && ready at a clk edge, on either side.
- States: S_IDLE, S_PASS.
- S_IDLE:
  - A port requests when valid=1 and sop=1.
  - Winner is the first requesting port searching upward from last_grant+1, wrapping modulo NUM_PORTS.
  - If a winner exists: grant<=winner, last_grant<=winner, state<=S_PASS (next cycle). Arbitration latency is 1 cycle; no beat is transferred in the arbitration cycle.
  - Any port with valid=1 and sop=0 in S_IDLE is a stray: stream_in_ready[p]=1 that cycle, the beat is discarded, drop_count+=1 per cycle if any stray exists. Multiple strays in one cycle still add only 1. drop_count saturates at 16'hFFFF.
  - Other ports' ready=0 in S_IDLE.
- S_PASS (combinational passthrough, zero latency):
  - stream_out_data/empty/valid/sop/eop = the granted port's signals; stream_out_channel=grant.
  - stream_in_ready[grant] = stream_out_ready; all other ready=0.
  - The granted input's valid may drop mid-packet; the grant is held.
  - On an accepted beat with eop=1: state<=S_IDLE. One idle cycle (bubble) always follows each packet.
  - A single-beat packet (sop=eop=1) passes and returns to S_IDLE the next cycle.
  - In S_IDLE stream_out_valid=0; data/empty/channel outputs are don't-care but must not be X (drive 0).
  - A second SOP from the granted port before EOP is forwarded unchanged; no validation is done.
- Fairness:
  - last_grant updates only on a grant. With all ports continuously requesting, grants rotate 0,1,...,NUM_PORTS-1,0.
  - Worst-case wait is NUM_PORTS-1 packets.
- Backpressure: stream_out_ready=0 stalls the granted port only; state is unchanged.
- Outputs are not registered in S_PASS; the downstream must tolerate combinational valid/data from upstream.

Test Plan:
- Single port: reset, then port0 sends a 3-beat packet (data 0x11111111, 0x22222222, 0x33333333, empty=2 on EOP), out_ready=1 -> output has 3 beats with SOP on the first and EOP with empty=2 on the third, channel=0; 1-cycle arbitration before, 1 idle cycle after.
- Contention: ports 0 and 1 both hold 2-beat packets from reset -> output order is port0, port1, port0, port1; channel alternates; no beats interleaved within a packet.
- Backpressure: port1 packet of 4 beats, out_ready low for 3 cycles in mid-packet -> stream_in_ready[1] low for those exact cycles; port0 ready stays 0; all 4 beats delivered intact.
- Stray beats: port1 valid=1, sop=0 for 5 cycles while idle -> ready[1]=1 for those cycles, nothing output, drop_count=5; preload near 16'hFFFE and drive 4 more -> saturates at 16'hFFFF.
- Single-beat packets: port0 sends sop=eop=1 packets back to back -> one output beat every 2 cycles; the FSM returns to S_IDLE each time.
- Reset mid-packet: assert reset after beat 2 of a 4-beat packet -> next cycle all ready=0, stream_out_valid=0, drop_count=0; after reset release a new port1 packet wins (last_grant reset means port0 priority, but port0 is idle).

Source files
------------

// File: rtl/stream_packet_arbiter_if.sv
// Stream bundle for the packet arbiter: NUM_PORTS packed input streams plus the
// merged output stream. master = sources/sink side, slave = the arbiter.
interface stream_packet_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int CH_W      = 1
);
  logic [NUM_PORTS*32-1:0] stream_in_data;
  logic [NUM_PORTS*2-1:0]  stream_in_empty;
  logic [NUM_PORTS-1:0]    stream_in_valid;
  logic [NUM_PORTS-1:0]    stream_in_startofpacket;
  logic [NUM_PORTS-1:0]    stream_in_endofpacket;
  logic [NUM_PORTS-1:0]    stream_in_ready;
  logic [31:0]             stream_out_data;
  logic [1:0]              stream_out_empty;
  logic                    stream_out_valid;
  logic                    stream_out_startofpacket;
  logic                    stream_out_endofpacket;
  logic [CH_W-1:0]         stream_out_channel;
  logic                    stream_out_ready;

  modport master (
    output stream_in_data, stream_in_empty, stream_in_valid,
           stream_in_startofpacket, stream_in_endofpacket, stream_out_ready,
    input  stream_in_ready, stream_out_data, stream_out_empty, stream_out_valid,
           stream_out_startofpacket, stream_out_endofpacket, stream_out_channel
  );

  modport slave (
    input  stream_in_data, stream_in_empty, stream_in_valid,
           stream_in_startofpacket, stream_in_endofpacket, stream_out_ready,
    output stream_in_ready, stream_out_data, stream_out_empty, stream_out_valid,
           stream_out_startofpacket, stream_out_endofpacket, stream_out_channel
  );
endinterface

// File: rtl/stream_packet_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS 32-bit streams; grant held SOP..EOP,
// stray non-SOP beats on idle ports are swallowed and counted (saturating).
module stream_packet_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int CH_W      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  stream_packet_arbiter_if.slave bus,
  output logic [15:0]            drop_count
);
  typedef enum logic {S_IDLE, S_PASS} state_t;

  state_t               state;
  logic [CH_W-1:0]      grant, last_grant, win_idx;
  logic                 win_found, pass;
  logic [NUM_PORTS-1:0] req, stray;
  logic [31:0]          g_data;
  logic [1:0]           g_empty;
  logic                 g_valid, g_sop, g_eop;

  assign req   = bus.stream_in_valid & bus.stream_in_startofpacket;
  assign stray = bus.stream_in_valid & ~bus.stream_in_startofpacket;
  assign pass  = (state == S_PASS) && !reset;

  function automatic logic [CH_W-1:0] port_at(input logic [CH_W-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_PORTS;
    return CH_W'(s);
  endfunction

  // search starts just above the previous winner, so every port gets a turn
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!win_found && req[port_at(last_grant, i)]) begin
        win_found = 1'b1;
        win_idx   = port_at(last_grant, i);
      end
    end
  end

  always_comb begin
    g_data  = '0;
    g_empty = '0;
    g_valid = 1'b0;
    g_sop   = 1'b0;
    g_eop   = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant == CH_W'(p)) begin
        g_data  = bus.stream_in_data[p*32 +: 32];
        g_empty = bus.stream_in_empty[p*2 +: 2];
        g_valid = bus.stream_in_valid[p];
        g_sop   = bus.stream_in_startofpacket[p];
        g_eop   = bus.stream_in_endofpacket[p];
      end
    end
  end

  // zero-latency passthrough while a packet owns the output; zeros otherwise
  always_comb begin
    bus.stream_out_valid         = pass && g_valid;
    bus.stream_out_data          = pass ? g_data  : '0;
    bus.stream_out_empty         = pass ? g_empty : '0;
    bus.stream_out_startofpacket = pass && g_sop;
    bus.stream_out_endofpacket   = pass && g_eop;
    bus.stream_out_channel       = pass ? grant : '0;
    bus.stream_in_ready          = '0;
    if (!reset) begin
      if (state == S_IDLE) begin
        bus.stream_in_ready = stray;
      end else begin
        for (int p = 0; p < NUM_PORTS; p++)
          bus.stream_in_ready[p] = (grant == CH_W'(p)) && bus.stream_out_ready;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_PORTS - 1);
      drop_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant      <= win_idx;
            last_grant <= win_idx;
            state      <= S_PASS;
          end
          // one increment per cycle no matter how many ports are stray
          if (|stray && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
        end
        S_PASS: begin
          if (g_valid && bus.stream_out_ready && g_eop)
            state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Directed bench for stream_packet_arbiter (2 ports): single packet, contention,
// backpressure, stray drops with saturation, single-beat packets, mid-packet reset.
module tb_stream_packet_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] drop_count;
  int          checks = 0, errors = 0;

  stream_packet_arbiter_if #(.NUM_PORTS(2), .CH_W(1)) bus ();

  stream_packet_arbiter #(.NUM_PORTS(2), .CH_W(1)) dut (
    .clk(clk), .reset(reset), .bus(bus), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p, input logic v, input logic sop, input logic eop,
                     input logic [31:0] d, input logic [1:0] e);
    bus.stream_in_valid[p]          = v;
    bus.stream_in_startofpacket[p]  = sop;
    bus.stream_in_endofpacket[p]    = eop;
    bus.stream_in_data[p*32 +: 32]  = d;
    bus.stream_in_empty[p*2 +: 2]   = e;
  endtask

  task automatic idle_all();
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic sop, input logic eop, input logic [1:0] em,
                         input logic ch, input logic [1:0] rdy);
    #1;
    chk({tag, "/valid"}, 32'(bus.stream_out_valid), 32'(v));
    chk({tag, "/data"},  bus.stream_out_data, d);
    chk({tag, "/empty"}, 32'(bus.stream_out_empty), 32'(em));
    chk({tag, "/chan"},  32'(bus.stream_out_channel), 32'(ch));
    chk({tag, "/ready"}, 32'(bus.stream_in_ready), 32'(rdy));
    if (v) begin
      chk({tag, "/sop"}, 32'(bus.stream_out_startofpacket), 32'(sop));
      chk({tag, "/eop"}, 32'(bus.stream_out_endofpacket), 32'(eop));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] cont_exp [8] = '{32'hA0000000, 32'hA0000001, 32'hA0000100, 32'hA0000101,
                                32'hA0000010, 32'hA0000011, 32'hA0000110, 32'hA0000111};
  int bi [2];
  int pk [2];
  int got_n;

  initial begin
    bus.stream_out_ready = 1'b1;
    reset = 1'b1;
    idle_all();
    // port1 stray during reset must not be accepted or counted
    drv(1, 1'b1, 1'b0, 1'b0, 32'hDEAD0000, 2'd0);
    tick();
    chk_out("rst", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
    chk("rst/drop", 32'(drop_count), 32'h0);
    idle_all();
    tick();
    reset = 1'b0;

    // single 3-beat packet on port 0
    drv(0, 1'b1, 1'b1, 1'b0, 32'h11111111, 2'd0);
    chk_out("single/arb", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
    tick();
    chk_out("single/b0", 1'b1, 32'h11111111, 1'b1, 1'b0, 2'd0, 1'b0, 2'b01);
    tick();
    drv(0, 1'b1, 1'b0, 1'b0, 32'h22222222, 2'd0);
    chk_out("single/b1", 1'b1, 32'h22222222, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01);
    tick();
    drv(0, 1'b1, 1'b0, 1'b1, 32'h33333333, 2'd2);
    chk_out("single/b2", 1'b1, 32'h33333333, 1'b0, 1'b1, 2'd2, 1'b0, 2'b01);
    tick();
    idle_all();
    chk_out("single/bubble", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
    tick();

    // contention: both ports hold two 2-beat packets each from reset
    do_reset();
    bi = '{0, 0};
    pk = '{0, 0};
    got_n = 0;
    for (int c = 0; c < 14; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (pk[p] < 2)
          drv(p, 1'b1, bi[p] == 0, bi[p] == 1,
              32'hA0000000 | 32'((p << 8) | (pk[p] << 4) | bi[p]), 2'd0);
        else
          drv(p, 1'b0, 1'b0, 1'b0, 32'h0, 2'd0);
      end
      #1;
      if (bus.stream_out_valid && bus.stream_out_ready) begin
        if (got_n < 8) begin
          chk("cont/data", bus.stream_out_data, cont_exp[got_n]);
          chk("cont/chan", 32'(bus.stream_out_channel), 32'((got_n >> 1) & 1));
          chk("cont/sop",  32'(bus.stream_out_startofpacket), 32'((got_n & 1) == 0));
          chk("cont/eop",  32'(bus.stream_out_endofpacket), 32'(got_n & 1));
        end
        got_n++;
      end
      for (int p = 0; p < 2; p++) begin
        if (bus.stream_in_ready[p] && bus.stream_in_valid[p]) begin
          bi[p]++;
          if (bi[p] == 2) begin
            bi[p] = 0;
            pk[p]++;
          end
        end
      end
      tick();
    end
    chk("cont/count", 32'(got_n), 32'd8);
    idle_all();

    // backpressure on a 4-beat port1 packet; port0 requests meanwhile
    do_reset();
    drv(1, 1'b1, 1'b1, 1'b0, 32'hB0000000, 2'd0);
    chk_out("bp/arb", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
    tick();
    drv(0, 1'b1, 1'b1, 1'b0, 32'hC0000000, 2'd0);
    chk_out("bp/b0", 1'b1, 32'hB0000000, 1'b1, 1'b0, 2'd0, 1'b1, 2'b10);
    tick();
    drv(1, 1'b1, 1'b0, 1'b0, 32'hB0000001, 2'd0);
    chk_out("bp/b1", 1'b1, 32'hB0000001, 1'b0, 1'b0, 2'd0, 1'b1, 2'b10);
    tick();
    drv(1, 1'b1, 1'b0, 1'b0, 32'hB0000002, 2'd0);
    bus.stream_out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      chk_out("bp/stall", 1'b1, 32'hB0000002, 1'b0, 1'b0, 2'd0, 1'b1, 2'b00);
      tick();
    end
    bus.stream_out_ready = 1'b1;
    chk_out("bp/b2", 1'b1, 32'hB0000002, 1'b0, 1'b0, 2'd0, 1'b1, 2'b10);
    tick();
    drv(1, 1'b1, 1'b0, 1'b1, 32'hB0000003, 2'd1);
    chk_out("bp/b3", 1'b1, 32'hB0000003, 1'b0, 1'b1, 2'd1, 1'b1, 2'b10);
    tick();
    idle_all();
    chk_out("bp/bubble", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
    tick();

    // stray beats on idle port1, then drive the counter into saturation
    do_reset();
    drv(1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 2'd0);
    for (int s = 0; s < 5; s++) begin
      chk_out("stray", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b10);
      tick();
    end
    idle_all();
    #1;
    chk("stray/drop5", 32'(drop_count), 32'd5);
    drv(1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 2'd0);
    repeat (65529) tick();
    idle_all();
    #1;
    chk("stray/dropFFFE", 32'(drop_count), 32'h0000FFFE);
    drv(1, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 2'd0);
    repeat (4) tick();
    idle_all();
    #1;
    chk("stray/sat", 32'(drop_count), 32'h0000FFFF);
    tick();

    // back-to-back single-beat packets: one output beat every other cycle
    for (int n = 0; n < 3; n++) begin
      drv(0, 1'b1, 1'b1, 1'b1, 32'h50000000 + 32'(n), 2'd3);
      chk_out("sb/idle", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
      tick();
      chk_out("sb/beat", 1'b1, 32'h50000000 + 32'(n), 1'b1, 1'b1, 2'd3, 1'b0, 2'b01);
      tick();
    end
    idle_all();
    chk("sb/drop", 32'(drop_count), 32'h0000FFFF);

    // reset in the middle of a 4-beat port0 packet
    drv(0, 1'b1, 1'b1, 1'b0, 32'h60000000, 2'd0);
    tick();
    tick();
    drv(0, 1'b1, 1'b0, 1'b0, 32'h60000001, 2'd0);
    chk_out("mid/b1", 1'b1, 32'h60000001, 1'b0, 1'b0, 2'd0, 1'b0, 2'b01);
    tick();
    drv(0, 1'b1, 1'b0, 1'b0, 32'h60000002, 2'd0);
    reset = 1'b1;
    chk_out("mid/inrst", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
    tick();
    chk_out("mid/after", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
    chk("mid/drop", 32'(drop_count), 32'h0);
    reset = 1'b0;
    idle_all();
    drv(1, 1'b1, 1'b1, 1'b1, 32'h61616161, 2'd1);
    chk_out("mid/arb", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
    tick();
    chk_out("mid/p1", 1'b1, 32'h61616161, 1'b1, 1'b1, 2'd1, 1'b1, 2'b10);
    tick();
    idle_all();
    chk_out("mid/bubble", 1'b0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 2'b00);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
